wf68k30l_dreg_writeback: RTL and testbench

Data-register writeback sequencer: buffers completed results from the execution stage and drives the write side of the data register file (`DR_WR_1/2`, `DR_SEL_WR_1/2`, `DR_IN_1/2`, `OP_SIZE`). It also issues `UNMARK` when the final write of an instruction retires, which clears the register file's in-use hazard tracking. It is the retire-side counterpart of the mark-used/hazard path: the issue stage marks destinations, this block writes them and releases them. It sits between the ALU/result mux and `WF68K30L_DATA_REGISTERS`.

---
 rtl/wf68k30l_dreg_writeback_if.sv | 44 ++++
 rtl/wf68k30l_dreg_writeback.sv | 127 ++++++++++++
 tb/tb_wf68k30l_dreg_writeback.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/wf68k30l_dreg_writeback_if.sv
// Writeback bus between the result mux / register file and the data-register
// writeback sequencer.
//   WB_*      : result entries offered by the execution stage (valid/ready)
//   RF_HOLD   : register-file write ports borrowed this cycle
//   FLUSH     : exception/branch flush
//   DR_*      : register-file write side (strobes, selects, data)
//   OP_SIZE   : write size, UNMARK : hazard release pulse, BUSY : activity
// master = result source / register file side, slave = the sequencer.
interface wf68k30l_dreg_writeback_if;
  logic        WB_VALID;
  logic        WB_READY;
  logic [2:0]  WB_SEL_1;
  logic [31:0] WB_DATA_1;
  logic [2:0]  WB_SEL_2;
  logic [31:0] WB_DATA_2;
  logic        WB_PAIR;
  logic [1:0]  WB_SIZE;
  logic        WB_LAST;
  logic        RF_HOLD;
  logic        FLUSH;
  logic        DR_WR_1;
  logic        DR_WR_2;
  logic [2:0]  DR_SEL_WR_1;
  logic [2:0]  DR_SEL_WR_2;
  logic [31:0] DR_IN_1;
  logic [31:0] DR_IN_2;
  logic [1:0]  OP_SIZE;
  logic        UNMARK;
  logic        BUSY;

  modport master (
    output WB_VALID, WB_SEL_1, WB_DATA_1, WB_SEL_2, WB_DATA_2, WB_PAIR,
           WB_SIZE, WB_LAST, RF_HOLD, FLUSH,
    input  WB_READY, DR_WR_1, DR_WR_2, DR_SEL_WR_1, DR_SEL_WR_2, DR_IN_1,
           DR_IN_2, OP_SIZE, UNMARK, BUSY
  );

  modport slave (
    input  WB_VALID, WB_SEL_1, WB_DATA_1, WB_SEL_2, WB_DATA_2, WB_PAIR,
           WB_SIZE, WB_LAST, RF_HOLD, FLUSH,
    output WB_READY, DR_WR_1, DR_WR_2, DR_SEL_WR_1, DR_SEL_WR_2, DR_IN_1,
           DR_IN_2, OP_SIZE, UNMARK, BUSY
  );
endinterface

// File: rtl/wf68k30l_dreg_writeback.sv
// Data-register writeback sequencer. Buffers completed results in a small
// circular FIFO and retires one entry per cycle into the data register file,
// pulsing UNMARK when the last write of an instruction retires.
// Ports:
//   CLK   : clock, rising edge
//   RESET : synchronous active-high reset (no UNMARK pulse)
//   bus   : writeback interface, slave side (see wf68k30l_dreg_writeback_if)
// Parameter DEPTH: queue entries, power of two, >= 2.
module wf68k30l_dreg_writeback #(
  parameter int DEPTH = 2
) (
  input  logic                         CLK,
  input  logic                         RESET,
  wf68k30l_dreg_writeback_if.slave     bus
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [2:0]  sel1;
    logic [31:0] data1;
    logic [2:0]  sel2;
    logic [31:0] data2;
    logic        pair;
    logic [1:0]  size;
    logic        last;
  } entry_t;

  typedef enum logic {IDLE, WRITE} state_t;

  entry_t        mem [DEPTH];
  entry_t        in_ent, head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          ready;
  logic          push, pop;
  state_t        state;

  logic          wr1_q, wr2_q, unmark_q;
  logic [2:0]    sel1_q, sel2_q;
  logic [31:0]   data1_q, data2_q;
  logic [1:0]    size_q;

  assign in_ent = '{sel1: bus.WB_SEL_1, data1: bus.WB_DATA_1,
                    sel2: bus.WB_SEL_2, data2: bus.WB_DATA_2,
                    pair: bus.WB_PAIR,  size:  bus.WB_SIZE,
                    last: bus.WB_LAST};
  assign head   = mem[rd_ptr];

  // ready comes from the registered count, so a full queue refuses a push
  // even in a cycle where it also pops.
  assign push = bus.WB_VALID && ready && !bus.FLUSH;
  assign pop  = (count != '0) && !bus.RF_HOLD && !bus.FLUSH;

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + (AW+1)'(1);
    else if (pop && !push) count_nxt = count - (AW+1)'(1);
  end

  // Storage needs no reset: validity is tracked by the pointers and count.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= in_ent;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ready    <= 1'b1;
      state    <= IDLE;
      wr1_q    <= 1'b0;
      wr2_q    <= 1'b0;
      unmark_q <= 1'b0;
      sel1_q   <= '0;
      sel2_q   <= '0;
      data1_q  <= '0;
      data2_q  <= '0;
      size_q   <= 2'b10;
    end else if (bus.FLUSH) begin
      // Flushed entries never write, but their hazard marks must still be
      // released: one IDLE cycle carrying UNMARK.
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ready    <= 1'b1;
      state    <= IDLE;
      wr1_q    <= 1'b0;
      wr2_q    <= 1'b0;
      unmark_q <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      ready <= (count_nxt != FULL_CNT);
      if (pop) begin
        state    <= WRITE;
        wr1_q    <= 1'b1;
        // Same destination on both halves of a pair op: port 1 wins alone.
        wr2_q    <= head.pair && (head.sel2 != head.sel1);
        unmark_q <= head.last;
        sel1_q   <= head.sel1;
        sel2_q   <= head.sel2;
        data1_q  <= head.data1;
        data2_q  <= head.data2;
        size_q   <= head.size;
      end else begin
        state    <= IDLE;
        wr1_q    <= 1'b0;
        wr2_q    <= 1'b0;
        unmark_q <= 1'b0;
      end
    end
  end

  assign bus.WB_READY    = ready;
  assign bus.DR_WR_1     = wr1_q;
  assign bus.DR_WR_2     = wr2_q;
  assign bus.DR_SEL_WR_1 = sel1_q;
  assign bus.DR_SEL_WR_2 = sel2_q;
  assign bus.DR_IN_1     = data1_q;
  assign bus.DR_IN_2     = data2_q;
  assign bus.OP_SIZE     = size_q;
  assign bus.UNMARK      = unmark_q;
  assign bus.BUSY        = (count != '0) || (state == WRITE) || unmark_q;
endmodule

// File: tb/tb_wf68k30l_dreg_writeback.sv
module tb_wf68k30l_dreg_writeback;
  localparam int DEPTH = 2;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  wf68k30l_dreg_writeback_if bus();
  wf68k30l_dreg_writeback #(.DEPTH(DEPTH)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  typedef struct packed {
    logic [2:0]  sel1;
    logic [31:0] data1;
    logic [2:0]  sel2;
    logic [31:0] data2;
    logic        pair;
    logic [1:0]  size;
    logic        last;
  } ent_t;

  typedef struct {
    bit          valid;
    ent_t        e;
    logic [76:0] exp;
  } vec_t;

  int n_cmp = 0, n_bad = 0, cyc = 0, n_unmark = 0;
  logic [31:0] wlog[$];

  // Reference model: a queue of pending entries plus the visible write state.
  ent_t        mq[$];
  logic        m_wr1, m_wr2, m_unmark;
  logic [2:0]  m_s1, m_s2;
  logic [31:0] m_d1, m_d2;
  logic [1:0]  m_size;

  function automatic ent_t mk(logic [2:0] s1, logic [31:0] d1, logic [2:0] s2,
                              logic [31:0] d2, logic p, logic [1:0] sz, logic l);
    return '{sel1: s1, data1: d1, sel2: s2, data2: d2, pair: p, size: sz, last: l};
  endfunction

  function automatic logic [76:0] outs(logic r, logic w1, logic w2, logic [2:0] s1,
                                       logic [2:0] s2, logic [31:0] d1, logic [31:0] d2,
                                       logic [1:0] sz, logic u, logic b);
    return {r, w1, w2, s1, s2, d1, d2, sz, u, b};
  endfunction

  function automatic logic [76:0] dut_outs();
    return outs(bus.WB_READY, bus.DR_WR_1, bus.DR_WR_2, bus.DR_SEL_WR_1, bus.DR_SEL_WR_2,
                bus.DR_IN_1, bus.DR_IN_2, bus.OP_SIZE, bus.UNMARK, bus.BUSY);
  endfunction

  task automatic chk(string name, logic [76:0] got, logic [76:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  task automatic drive(bit v, ent_t e, bit h, bit f);
    bus.WB_VALID  = v;
    bus.WB_SEL_1  = e.sel1;
    bus.WB_DATA_1 = e.data1;
    bus.WB_SEL_2  = e.sel2;
    bus.WB_DATA_2 = e.data2;
    bus.WB_PAIR   = e.pair;
    bus.WB_SIZE   = e.size;
    bus.WB_LAST   = e.last;
    bus.RF_HOLD   = h;
    bus.FLUSH     = f;
  endtask

  // One clock: advance model and DUT, then compare every output.
  task automatic tick();
    ent_t in, h;
    bit   do_push, do_pop;
    @(posedge CLK);
    in = mk(bus.WB_SEL_1, bus.WB_DATA_1, bus.WB_SEL_2, bus.WB_DATA_2,
            bus.WB_PAIR, bus.WB_SIZE, bus.WB_LAST);
    if (RESET) begin
      mq.delete();
      m_wr1 = 0; m_wr2 = 0; m_unmark = 0;
      m_s1 = 0; m_s2 = 0; m_d1 = 0; m_d2 = 0; m_size = 2'b10;
    end else if (bus.FLUSH) begin
      mq.delete();
      m_wr1 = 0; m_wr2 = 0; m_unmark = 1;
    end else begin
      do_push = bus.WB_VALID && (mq.size() < DEPTH);
      do_pop  = (mq.size() > 0) && !bus.RF_HOLD;
      if (do_pop) begin
        h = mq.pop_front();
        m_wr1 = 1; m_wr2 = h.pair && (h.sel1 != h.sel2); m_unmark = h.last;
        m_s1 = h.sel1; m_s2 = h.sel2; m_d1 = h.data1; m_d2 = h.data2; m_size = h.size;
      end else begin
        m_wr1 = 0; m_wr2 = 0; m_unmark = 0;
      end
      if (do_push) mq.push_back(in);
    end
    #1;
    cyc++;
    chk("model", dut_outs(),
        outs(mq.size() < DEPTH, m_wr1, m_wr2, m_s1, m_s2, m_d1, m_d2, m_size, m_unmark,
             (mq.size() != 0) || m_wr1 || m_unmark));
    if (bus.DR_WR_1) wlog.push_back(bus.DR_IN_1);
    if (bus.UNMARK) n_unmark++;
  endtask

  vec_t vt[$];
  task automatic addv(bit v, ent_t e, logic [76:0] x);
    vec_t r;
    r.valid = v; r.e = e; r.exp = x;
    vt.push_back(r);
  endtask

  initial begin
    ent_t z;
    z = mk(0, 0, 0, 0, 0, 0, 0);
    RESET = 1'b1;
    drive(0, z, 0, 0);
    tick(); tick();
    chk("reset_state", dut_outs(), outs(1, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0));
    RESET = 1'b0;

    // ---- table: single long write, pair write, same-sel pair, byte write
    addv(1, mk(3, 32'hDEADBEEF, 0, 0, 0, 2, 1), outs(1,0,0,0,0,0,0,2,0,1));
    addv(0, z, outs(1,1,0,3,0,32'hDEADBEEF,0,2,1,1));
    addv(0, z, outs(1,0,0,3,0,32'hDEADBEEF,0,2,0,0));
    addv(1, mk(2, 32'h11111111, 5, 32'h22222222, 1, 2, 1), outs(1,0,0,3,0,32'hDEADBEEF,0,2,0,1));
    addv(1, mk(4, 32'h33333333, 4, 32'h44444444, 1, 1, 1),
         outs(1,1,1,2,5,32'h11111111,32'h22222222,2,1,1));
    addv(0, z, outs(1,1,0,4,4,32'h33333333,32'h44444444,1,1,1));
    addv(0, z, outs(1,0,0,4,4,32'h33333333,32'h44444444,1,0,0));
    addv(1, mk(7, 32'hAB, 0, 0, 0, 0, 0), outs(1,0,0,4,4,32'h33333333,32'h44444444,1,0,1));
    addv(0, z, outs(1,1,0,7,0,32'hAB,0,0,0,1));
    addv(0, z, outs(1,0,0,7,0,32'hAB,0,0,0,0));
    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].valid, vt[i].e, 0, 0);
      tick();
      chk($sformatf("vec%0d", i), dut_outs(), vt[i].exp);
    end

    // ---- full/hold: third entry held by the source until accepted
    drive(1, mk(1, 32'hA0, 0, 0, 0, 2, 0), 1, 0); tick();
    chk("hold_ready1", bus.WB_READY, 1);
    drive(1, mk(1, 32'hA1, 0, 0, 0, 2, 0), 1, 0); tick();
    chk("hold_ready0", bus.WB_READY, 0);
    drive(1, mk(1, 32'hA2, 0, 0, 0, 2, 1), 1, 0); tick();
    chk("hold_full", {bus.WB_READY, bus.DR_WR_1}, 0);
    bus.RF_HOLD = 0; tick();
    chk("hold_ret0", {bus.DR_WR_1, bus.DR_IN_1, bus.UNMARK}, {1'b1, 32'hA0, 1'b0});
    tick();
    chk("hold_ret1", {bus.DR_WR_1, bus.DR_IN_1, bus.UNMARK}, {1'b1, 32'hA1, 1'b0});
    bus.WB_VALID = 0; tick();
    chk("hold_ret2", {bus.DR_WR_1, bus.DR_IN_1, bus.UNMARK}, {1'b1, 32'hA2, 1'b1});
    tick();
    chk("hold_done", {bus.DR_WR_1, bus.UNMARK}, 0);

    // ---- flush with concurrent push
    drive(1, mk(2, 32'hF1, 0, 0, 0, 2, 0), 1, 0); tick();
    drive(1, mk(2, 32'hF2, 0, 0, 0, 2, 1), 1, 0); tick();
    wlog.delete();
    drive(1, mk(6, 32'hF00D, 0, 0, 0, 2, 1), 0, 1); tick();
    chk("flush_n1", {bus.DR_WR_1, bus.DR_WR_2, bus.UNMARK}, 3'b001);
    drive(0, z, 0, 0); tick();
    chk("flush_busy", {bus.BUSY, bus.UNMARK}, 0);
    drive(1, mk(5, 32'hF3, 0, 0, 0, 2, 1), 1, 0); tick();
    drive(1, mk(6, 32'hF00E, 0, 0, 0, 2, 1), 1, 1); tick();
    chk("flush2_unmark", {bus.DR_WR_1, bus.UNMARK, bus.WB_READY}, 3'b011);
    drive(0, z, 0, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("flush_nowrite", wlog.size(), 0);

    // ---- wrap-around: 9 back-to-back entries
    wlog.delete();
    for (int i = 0; i < 9; i++) begin
      drive(1, mk(3'(i), 32'(i), 0, 0, 0, 2, i == 8), 0, 0);
      tick();
      chk($sformatf("wrap_ready%0d", i), bus.WB_READY, 1);
    end
    drive(0, z, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    chk("wrap_count", wlog.size(), 9);
    for (int i = 0; i < 9 && i < wlog.size(); i++)
      chk($sformatf("wrap_data%0d", i), wlog[i], 32'(i));

    // ---- reset mid-stream
    drive(1, mk(1, 32'hB0, 0, 0, 0, 1, 1), 1, 0); tick();
    drive(1, mk(1, 32'hB1, 0, 0, 0, 0, 1), 1, 0); tick();
    drive(0, z, 1, 0);
    RESET = 1'b1; tick();
    chk("rst_mid", dut_outs(), outs(1, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0));
    RESET = 1'b0;
    bus.RF_HOLD = 0;
    wlog.delete(); n_unmark = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("rst_quiet", {wlog.size(), n_unmark}, 0);

    // ---- randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 9) < 7,
            mk(3'($urandom), $urandom, 3'($urandom), $urandom, 1'($urandom),
               2'($urandom_range(0, 2)), 1'($urandom)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0);
      RESET = ($urandom_range(0, 199) == 0);
      tick();
    end
    RESET = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
